// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised inter-stage pipeline buffer.
package pipe_pkg;

    // Bubble constants: an empty or killed entry holds a nop at the reset pc.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Occupancy of the buffer; StTwo is only reachable with the skid register.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } buf_state_e;

    // Control fields carried with every instruction; the payload is appended below a3.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  a3;
    } entry_t;

    function automatic entry_t bubble_entry(input logic [31:0] pc);
        entry_t e;
        e.pc    = pc;
        e.instr = NOP_INSTR;
        e.a3    = 5'd0;
        return e;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry register: async active-low reset to the bubble, load enable.
module pipe_entry_reg #(
    parameter int unsigned W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] entry_q;

    // Hold the entry until a load; reset returns it to the bubble value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q <= RESET_VAL;
        end else if (en_i) begin
            entry_q <= d_i;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage buffer with optional two-entry skid, flush and stall counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned SKID     = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic [4:0]        in_a3,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [4:0]        out_a3,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned W = $bits(entry_t) + DATA_W;
    localparam logic [W-1:0] BUBBLE = {bubble_entry(RESET_PC), {DATA_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    buf_state_e state_q, state_d;
    entry_t     in_ent;
    logic [W-1:0] in_word, main_d, main_q, skid_d, skid_q;
    logic main_en, skid_en, do_accept, do_release;
    logic [CNT_W-1:0] stall_q;

    assign in_ent    = '{pc: in_pc, instr: in_instr, a3: in_a3};
    assign in_word   = {in_ent, in_data};
    assign out_valid = (state_q != StEmpty);

    // With the skid register in_ready depends only on state; without it, on downstream ready.
    assign in_ready   = (SKID != 0) ? (state_q != StTwo) : (!out_valid || out_ready);
    assign do_accept  = in_valid && in_ready;
    assign do_release = out_valid && out_ready;

    // Occupancy transitions and register load selects; flush beats accept and release.
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = in_word;
        skid_en = 1'b0;
        skid_d  = in_word;
        if (flush) begin
            state_d = StEmpty;
            main_en = 1'b1;
            main_d  = BUBBLE;
            skid_en = (SKID != 0);
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (do_accept) begin
                        state_d = StOne;
                        main_en = 1'b1;
                    end
                end
                StOne: begin
                    if (do_accept && !do_release && (SKID != 0)) begin
                        state_d = StTwo;
                        skid_en = 1'b1;
                    end else if (do_accept) begin
                        main_en = 1'b1;
                    end else if (do_release) begin
                        state_d = StEmpty;
                        main_en = 1'b1;
                        main_d  = BUBBLE;
                    end
                end
                StTwo: begin
                    if (do_release) begin
                        state_d = StOne;
                        main_en = 1'b1;
                        main_d  = skid_q;
                        skid_en = 1'b1;
                        skid_d  = BUBBLE;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Saturating back-pressure counter; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    pipe_entry_reg #(
        .W        (W),
        .RESET_VAL(BUBBLE)
    ) u_main (
        .clk_i (clk),
        .rst_ni(reset),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    if (SKID != 0) begin : g_skid
        pipe_entry_reg #(
            .W        (W),
            .RESET_VAL(BUBBLE)
        ) u_skid (
            .clk_i (clk),
            .rst_ni(reset),
            .en_i  (skid_en),
            .d_i   (skid_d),
            .q_o   (skid_q)
        );
    end else begin : g_no_skid
        assign skid_q = BUBBLE;
    end

    assign {out_pc, out_instr, out_a3, out_data} = main_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised and directed bench for pipe_stage_buf against a FIFO reference model.
module tb_pipe_stage_buf;

    localparam int unsigned DW = 64;

    typedef struct packed {
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic [4:0]    a3;
        logic [DW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic [4:0] in_a3 = '0;
    logic [DW-1:0] in_data = '0;

    // Index 0: SKID=1 CNT_W=16, 1: SKID=0 CNT_W=16, 2: SKID=1 CNT_W=4.
    logic o_valid[3];
    logic o_ready[3];
    logic [31:0] o_pc[3];
    logic [31:0] o_instr[3];
    logic [4:0] o_a3[3];
    logic [DW-1:0] o_data[3];
    logic [15:0] stall_a, stall_b;
    logic [3:0] stall_c;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each buffer is a bounded FIFO of capacity m_cap.
    ent_t m_buf[3][2];
    int m_cnt[3];
    int m_stall[3];
    int m_cap[3] = '{2, 1, 2};
    int m_max[3] = '{65535, 65535, 15};

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DW), .RESET_PC(32'h3000), .SKID(1), .CNT_W(16)) u_dut_skid (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(o_ready[0]),
        .in_pc(in_pc), .in_instr(in_instr), .in_a3(in_a3), .in_data(in_data),
        .out_valid(o_valid[0]), .out_ready(out_ready), .out_pc(o_pc[0]), .out_instr(o_instr[0]),
        .out_a3(o_a3[0]), .out_data(o_data[0]), .stall_cycles(stall_a)
    );

    pipe_stage_buf #(.DATA_W(DW), .RESET_PC(32'h3000), .SKID(0), .CNT_W(16)) u_dut_noskid (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(o_ready[1]),
        .in_pc(in_pc), .in_instr(in_instr), .in_a3(in_a3), .in_data(in_data),
        .out_valid(o_valid[1]), .out_ready(out_ready), .out_pc(o_pc[1]), .out_instr(o_instr[1]),
        .out_a3(o_a3[1]), .out_data(o_data[1]), .stall_cycles(stall_b)
    );

    pipe_stage_buf #(.DATA_W(DW), .RESET_PC(32'h3000), .SKID(1), .CNT_W(4)) u_dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(o_ready[2]),
        .in_pc(in_pc), .in_instr(in_instr), .in_a3(in_a3), .in_data(in_data),
        .out_valid(o_valid[2]), .out_ready(out_ready), .out_pc(o_pc[2]), .out_instr(o_instr[2]),
        .out_a3(o_a3[2]), .out_data(o_data[2]), .stall_cycles(stall_c)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t bubble();
        ent_t e;
        e.pc    = 32'h0000_3000;
        e.instr = '0;
        e.a3    = '0;
        e.data  = '0;
        return e;
    endfunction

    function automatic logic m_ready(input int i);
        if (m_cap[i] == 2) return (m_cnt[i] < 2);
        return (m_cnt[i] == 0) || out_ready;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]   = 0;
            m_stall[i] = 0;
        end
    endtask

    // Apply one clock edge to the model using the inputs present at that edge.
    task automatic model_edge();
        ent_t in_e;
        logic rdy, rel, acc;
        in_e = '{pc: in_pc, instr: in_instr, a3: in_a3, data: in_data};
        for (int i = 0; i < 3; i++) begin
            rdy = m_ready(i);
            rel = (m_cnt[i] > 0) && out_ready;
            acc = in_valid && rdy;
            if ((m_cnt[i] > 0) && !out_ready && (m_stall[i] < m_max[i])) m_stall[i]++;
            if (flush) begin
                m_cnt[i] = 0;
            end else begin
                if (rel) begin
                    m_buf[i][0] = m_buf[i][1];
                    m_cnt[i]--;
                end
                if (acc) begin
                    m_buf[i][m_cnt[i]] = in_e;
                    m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic check_dut(input int i);
        ent_t exp;
        logic [15:0] st;
        exp = (m_cnt[i] > 0) ? m_buf[i][0] : bubble();
        st  = (i == 0) ? stall_a : ((i == 1) ? stall_b : {12'd0, stall_c});
        check_eq($sformatf("u%0d_valid", i), o_valid[i], m_cnt[i] > 0);
        check_eq($sformatf("u%0d_in_ready", i), o_ready[i], m_ready(i));
        check_eq($sformatf("u%0d_pc", i), o_pc[i], exp.pc);
        check_eq($sformatf("u%0d_instr", i), o_instr[i], exp.instr);
        check_eq($sformatf("u%0d_a3", i), o_a3[i], exp.a3);
        check_eq($sformatf("u%0d_data", i), o_data[i], exp.data);
        check_eq($sformatf("u%0d_stall", i), st, m_stall[i][15:0]);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = $urandom;
        in_a3     = 5'($urandom);
        in_data   = {$urandom, $urandom};
        out_ready = rdy;
        flush     = fl;
    endtask

    // Check all outputs mid-cycle, then advance one clock in both DUTs and model.
    task automatic step();
        #1;
        for (int i = 0; i < 3; i++) check_dut(i);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_dut(i);
        check_eq("reset_pc", o_pc[0], 32'h3000);
        check_eq("reset_in_ready", o_ready[0], 1'b1);
        reset = 1'b1;

        // Streaming at full rate.
        drive(1'b1, 32'h3000, 1'b1, 1'b0); step();
        drive(1'b1, 32'h3004, 1'b1, 1'b0); step();
        drive(1'b1, 32'h3008, 1'b1, 1'b0); step();
        check_eq("stream_pc", o_pc[0], 32'h3008);
        check_eq("stream_in_ready", o_ready[0], 1'b1);
        check_eq("stream_stall", stall_a, 16'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0); step();

        // Back-pressure fill of the skid buffer, then drain.
        drive(1'b1, 32'h3010, 1'b0, 1'b0); step();
        drive(1'b1, 32'h3014, 1'b0, 1'b0); step();
        check_eq("bp_in_ready", o_ready[0], 1'b0);
        check_eq("bp_head", o_pc[0], 32'h3010);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) step();
        check_eq("bp_stall", stall_a, 16'd4);
        drive(1'b0, 32'h0, 1'b1, 1'b0); step();
        check_eq("bp_second", o_pc[0], 32'h3014);
        check_eq("bp_ready_back", o_ready[0], 1'b1);
        step();

        // Flush while full collides with an input that must be dropped.
        drive(1'b1, 32'h3018, 1'b0, 1'b0); step();
        drive(1'b1, 32'h301c, 1'b0, 1'b0); step();
        drive(1'b1, 32'h3020, 1'b0, 1'b1); step();
        check_eq("flush_valid", o_valid[0], 1'b0);
        check_eq("flush_pc", o_pc[0], 32'h3000);
        check_eq("flush_instr", o_instr[0], 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (2) step();

        // Asynchronous reset between edges while holding one entry.
        drive(1'b1, 32'h3030, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("arst_valid", o_valid[0], 1'b0);
        check_eq("arst_pc", o_pc[0], 32'h3000);
        check_eq("arst_stall", stall_a, 16'd0);
        for (int i = 0; i < 3; i++) check_dut(i);
        @(negedge clk);
        reset = 1'b1;

        // Combinational in_ready of the single-register build.
        drive(1'b1, 32'h3040, 1'b0, 1'b0); step();
        drive(1'b1, 32'h3044, 1'b0, 1'b0);
        #1;
        check_eq("noskid_ready_lo", o_ready[1], 1'b0);
        out_ready = 1'b1;
        #1;
        check_eq("noskid_ready_hi", o_ready[1], 1'b1);
        step();
        check_eq("noskid_replace", o_pc[1], 32'h3044);

        // Saturation of the narrow counter.
        drive(1'b1, 32'h3050, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (20) step();
        check_eq("sat_stall", stall_c, 4'd15);

        // Random traffic with occasional flushes.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
